sw_debounce_sync: RTL and testbench

//  Input-conditioning stage directly upstream of the switch-driven mux datapath.

---
 rtl/sw_debounce_sync_pkg.sv | 11 +
 rtl/sw_debounce_sync_debounce_bit.sv | 51 +++++
 rtl/sw_debounce_sync.sv | 37 +++
 tb/tb_sw_debounce_sync.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_sync_pkg.sv
// Board-level constants for the DE1-SoC switch conditioning path.
package sw_debounce_sync_pkg;
  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_20MS = 1_000_000;
  localparam int SW_WIDTH      = 10;

  // Width of a counter that can hold 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sw_debounce_sync_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and registered edge pulses.
module debounce_bit
  import sw_debounce_sync_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = DEBOUNCE_20MS,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic sw_in,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic busy
);
  localparam int            CW   = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_reg   <= RESET_BIT;
      s2_reg   <= RESET_BIT;
      sw_clean <= RESET_BIT;
      cnt_reg  <= '0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      s1_reg  <= sw_in;
      s2_reg  <= s1_reg;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      if (s2_reg == sw_clean) begin
        cnt_reg <= '0;
      end else if (cnt_reg == TERM) begin
        // Candidate held long enough: accept it and flag the direction.
        sw_clean <= s2_reg;
        cnt_reg  <= '0;
        sw_rise  <= s2_reg;
        sw_fall  <= ~s2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign busy = (cnt_reg != '0);
endmodule

// File: rtl/sw_debounce_sync.sv
// Synchronises and debounces the slide switches bit by bit before they reach the mux stage.
module sw_debounce_sync
  import sw_debounce_sync_pkg::*;
#(
  parameter int               WIDTH        = SW_WIDTH,
  parameter int               DEBOUNCE_CYC = DEBOUNCE_20MS,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             busy
);
  logic [WIDTH-1:0] busy_bits;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .RESET_BIT   (RESET_VAL[gi])
      ) u_bit (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .sw_in   (sw_in[gi]),
        .sw_clean(sw_clean[gi]),
        .sw_rise (sw_rise[gi]),
        .sw_fall (sw_fall[gi]),
        .busy    (busy_bits[gi])
      );
    end
  endgenerate

  assign busy = |busy_bits;
endmodule

// File: tb/tb_sw_debounce_sync.sv
// Scoreboard bench: window-based reference model pushes expectations, a negedge monitor checks them.
module tb_sw_debounce_sync;
  localparam int               WIDTH = 10;
  localparam int               N     = 4;
  localparam logic [WIDTH-1:0] RV    = '0;

  logic             CLOCK_50 = 1'b0;
  logic             resetn   = 1'b0;
  logic [WIDTH-1:0] sw_in    = '1;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             busy;

  sw_debounce_sync #(
    .WIDTH       (WIDTH),
    .DEBOUNCE_CYC(N),
    .RESET_VAL   (RV)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .sw_in   (sw_in),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .busy    (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             busy;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] raw_q[$];   // raw samples, [0] = previous edge, [1] = two edges back
  logic [WIDTH-1:0] s_hist[$];  // synchronised values seen at recent edges, [0] newest
  int               since[WIDTH];
  logic [WIDTH-1:0] m_clean;
  int               vectors     = 0;
  int               miscompares = 0;

  // Reference: a bit changes once the synchronised value has differed from the clean
  // value on each of the last N edges, all of them after the previous change/reset.
  always @(posedge CLOCK_50) begin : model
    exp_t             e;
    logic [WIDTH-1:0] s;
    bit               all_diff;
    e = '0;
    if (!resetn) begin
      raw_q = {RV, RV};
      s_hist.delete();
      for (int i = 0; i < WIDTH; i++) since[i] = 0;
      m_clean = RV;
    end else begin
      s = raw_q[1];
      raw_q.push_front(sw_in);
      void'(raw_q.pop_back());
      s_hist.push_front(s);
      if (s_hist.size() > N) void'(s_hist.pop_back());
      for (int i = 0; i < WIDTH; i++) begin
        since[i]++;
        all_diff = (since[i] >= N) && (s_hist.size() >= N);
        for (int j = 0; j < N && j < s_hist.size(); j++)
          if (s_hist[j][i] == m_clean[i]) all_diff = 0;
        if (all_diff) begin
          m_clean[i] = s[i];
          since[i]   = 0;
          e.rise[i]  = s[i];
          e.fall[i]  = ~s[i];
        end else if (s[i] != m_clean[i]) begin
          e.busy = 1'b1;
        end
      end
    end
    e.clean = m_clean;
    exp_q.push_back(e);
  end

  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({sw_clean, sw_rise, sw_fall, busy} !== e) begin
        miscompares++;
        $display("FAIL vec %0d: got clean=%h rise=%h fall=%h busy=%b, want clean=%h rise=%h fall=%h busy=%b",
                 vectors, sw_clean, sw_rise, sw_fall, busy, e.clean, e.rise, e.fall, e.busy);
      end else begin
        $display("vec %0d: clean=%h rise=%h fall=%h busy=%b", vectors, sw_clean, sw_rise, sw_fall, busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check(input string what, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL check %s: got %h want %h", what, got, want);
    end else begin
      $display("check %s: %h ok", what, got);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] flip;
    // Reset held with all switches up.
    resetn = 1'b0; sw_in = '1;
    tick(3);
    check("reset clean", sw_clean, '0);
    check("reset rise",  sw_rise,  '0);
    check("reset fall",  sw_fall,  '0);
    check("reset busy",  WIDTH'(busy), '0);
    resetn = 1'b1; sw_in = '0;
    tick(8);
    // Clean edge on bit 0.
    sw_in[0] = 1'b1;
    tick(N + 1);
    check("edge not yet expired clean0", WIDTH'(sw_clean[0]), WIDTH'(1'b0));
    tick(1);
    check("edge expired clean0", WIDTH'(sw_clean[0]), WIDTH'(1'b1));
    check("edge expired rise0",  WIDTH'(sw_rise[0]),  WIDTH'(1'b1));
    tick(10 - N - 2);
    // Bounce on bit 1, then settle high.
    sw_in[1] = 1'b1; tick(1);
    sw_in[1] = 1'b0; tick(1);
    sw_in[1] = 1'b1; tick(1);
    sw_in[1] = 1'b0; tick(1);
    sw_in[1] = 1'b1; tick(10);
    // Short glitch on bit 2.
    sw_in[2] = 1'b1; tick(3);
    sw_in[2] = 1'b0; tick(10);
    // Parallel select + data bits, both directions.
    sw_in = 10'h201; tick(10);
    sw_in = 10'h000; tick(10);
    // Reset in the middle of qualifying bit 3.
    sw_in[3] = 1'b1; tick(4);
    resetn = 1'b0;   tick(1);
    resetn = 1'b1;   tick(10);
    // Randomised switch activity with occasional resets and quiet stretches.
    for (int k = 0; k < 600; k++) begin
      flip = WIDTH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) sw_in = sw_in ^ flip;
      resetn = ($urandom_range(0, 199) != 0);
      tick(1);
      if ($urandom_range(0, 39) == 0) begin
        resetn = 1'b1;
        tick(N + 4);
      end
    end
    resetn = 1'b1;
    tick(N + 6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
